// File: rtl/wb_arbiter.sv
// Write-back arbiter with pending-write scoreboard for the register file write port.
// Optional WB_FWD_EN macro adds a byte-lane forwarding mux on two read ports.
module wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_waddr,
    input  logic [NREQ*4-1:0]    req_we,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_waddr,
    output logic                 issue_ready,
    input  logic [4:0]           chk_addr1,
    input  logic [4:0]           chk_addr2,
    output logic                 chk_busy1,
    output logic                 chk_busy2,
    output logic [3:0]           rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]           fwd_raddr1,
    input  logic [4:0]           fwd_raddr2,
    input  logic [31:0]          fwd_rdata1_i,
    input  logic [31:0]          fwd_rdata2_i,
    output logic [31:0]          fwd_rdata1_o,
    output logic [31:0]          fwd_rdata2_o
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             gnt_found;

    logic [3:0]       rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             commit_q, commit_d;

    logic [4:0]       sel_waddr;
    logic [3:0]       sel_we;
    logic [31:0]      sel_wdata;

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             inc_en, dec_en;
    logic             inc_r, dec_r;

    // Round-robin search begins one past the last winner.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
        ptr_d = gnt_found ? gnt_idx : ptr_q;
    end

    always_comb begin
        sel_waddr  = req_waddr[int'(gnt_idx)*5 +: 5];
        sel_we     = req_we[int'(gnt_idx)*4 +: 4];
        sel_wdata  = req_wdata[int'(gnt_idx)*32 +: 32];
        rf_we_d    = 4'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        commit_d   = gnt_found;
        if (gnt_found) begin
            rf_waddr_d = sel_waddr;
            rf_wdata_d = sel_wdata;
            rf_we_d    = (sel_waddr == 5'd0) ? 4'b0 : sel_we;
        end
    end

    // Issue readiness ignores a same-cycle decrement on purpose.
    assign issue_ready = (cnt_q[issue_waddr] != CNT_MAX) || (issue_waddr == 5'd0);
    assign inc_en      = issue_valid && issue_ready && (issue_waddr != 5'd0);
    assign dec_en      = commit_q && (rf_waddr_q != 5'd0);

    always_comb begin
        inc_r = 1'b0;
        dec_r = 1'b0;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_r    = inc_en && (issue_waddr == 5'(r));
            dec_r    = dec_en && (rf_waddr_q == 5'(r)) && (cnt_q[r] != '0);
            if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_r && !inc_r) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
        cnt_d[0] = '0;
    end

    assign chk_busy1 = (cnt_q[chk_addr1] != '0);
    assign chk_busy2 = (cnt_q[chk_addr2] != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q      <= PTR_RST;
            rf_we_q    <= 4'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            commit_q   <= 1'b0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            commit_q   <= commit_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // A commit to a register with no pending issue means decode lost track of it.
    dec_underflow_a: assert property (@(posedge clk) disable iff (!resetn)
        dec_en |-> (cnt_q[rf_waddr_q] != '0));

`ifdef WB_FWD_EN
    function automatic logic [31:0] fwd_merge(input logic [4:0] raddr, input logic [31:0] raw);
        logic [31:0] res;
        res = raw;
        for (int b = 0; b < 4; b++) begin
            if (rf_we_q[b] && (raddr == rf_waddr_q) && (rf_waddr_q != 5'd0)) begin
                res[b*8 +: 8] = rf_wdata_q[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign fwd_rdata1_o = fwd_merge(fwd_raddr1, fwd_rdata1_i);
    assign fwd_rdata2_o = fwd_merge(fwd_raddr2, fwd_rdata2_i);
`endif

endmodule
